// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives a combinational instruction memory,
// and presents one registered instruction per cycle through a valid/ready slot.
module imem_fetch_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     MEM_WORDS = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [31:0]     fetch_count
);

    localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(4 * MEM_WORDS - 4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     count_q, count_d;
    logic            slot_free;
    logic            handshake;

    function automatic logic in_range(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
    endfunction

    assign slot_free = !valid_q || inst_ready;
    assign handshake = valid_q && inst_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            ipc_q      <= '0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            ipc_q      <= ipc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    // Next-state: redirect beats issue beats drain; FAULT only drains
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        ipc_d      = ipc_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;

        if (handshake) begin
            count_d = count_q + 32'd1;
        end

        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (in_range(redirect_pc)) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d    = FAULT;
                        fault_pc_d = redirect_pc;
                    end
                end else if (fetch_en && slot_free) begin
                    if (in_range(pc_q)) begin
                        inst_d  = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end else begin
                        state_d    = FAULT;
                        fault_pc_d = pc_q;
                        valid_d    = valid_q && !inst_ready;
                    end
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end
            FAULT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst_out    = inst_q;
    assign inst_pc     = ipc_q;
    assign fault       = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a transaction-level model predicts every delivered
// instruction and the visible state; an independent monitor compares on each handshake.
module tb_imem_fetch_ctrl;

    localparam int unsigned MEM_WORDS = 32;
    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] widx;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        sb_q[$];

    // Reference model: visible state now and after the coming edge
    logic [31:0] m_pc = RESET_PC, m_pc_n;
    logic        m_valid = 1'b0, m_valid_n;
    logic [31:0] m_ipc = 32'h0, m_ipc_n;
    logic [31:0] m_inst = 32'h0, m_inst_n;
    logic        m_fault = 1'b0, m_fault_n;
    logic [31:0] m_fpc = 32'h0, m_fpc_n;
    logic [31:0] m_cnt = 32'h0, m_cnt_n;

    imem_fetch_ctrl #(
        .XLEN      (32),
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign widx       = imem_addr >> 2;
    assign imem_rdata = (imem_addr < MEM_BYTES) ? mem[widx[AW-1:0]] : 32'hBAD0_0BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < MEM_BYTES);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a / 4];
    endfunction

    // Predict the effect of the coming edge from the inputs just applied
    task automatic model_step();
        logic hs;
        hs        = m_valid && inst_ready;
        m_pc_n    = m_pc;
        m_valid_n = m_valid;
        m_ipc_n   = m_ipc;
        m_inst_n  = m_inst;
        m_fault_n = m_fault;
        m_fpc_n   = m_fpc;
        m_cnt_n   = m_cnt + (hs ? 32'd1 : 32'd0);
        if (hs) sb_q.push_back('{pc: m_ipc, inst: m_inst});
        if (!m_fault && redirect_valid) begin
            m_valid_n = 1'b0;
            if (legal(redirect_pc)) m_pc_n = redirect_pc;
            else begin m_fault_n = 1'b1; m_fpc_n = redirect_pc; end
        end else if (!m_fault && fetch_en && (!m_valid || inst_ready)) begin
            if (legal(m_pc)) begin
                m_valid_n = 1'b1;
                m_ipc_n   = m_pc;
                m_inst_n  = word_at(m_pc);
                m_pc_n    = m_pc + 32'd4;
            end else begin
                m_fault_n = 1'b1;
                m_fpc_n   = m_pc;
                m_valid_n = m_valid && !inst_ready;
            end
        end else if (hs) begin
            m_valid_n = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 1'b0; m_ipc = 32'h0; m_inst = 32'h0;
        m_fault = 1'b0; m_fpc = 32'h0; m_cnt = 32'h0;
        sb_q.delete();
    endtask

    task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        fetch_en = fe; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        model_step();
        @(posedge clk);
        #1;
        m_pc = m_pc_n; m_valid = m_valid_n; m_ipc = m_ipc_n; m_inst = m_inst_n;
        m_fault = m_fault_n; m_fpc = m_fpc_n; m_cnt = m_cnt_n;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic do_reset();
        @(negedge clk);
        fetch_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        @(negedge clk);
        #3 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'(4 * $urandom_range(0, MEM_WORDS - 1) + $urandom_range(1, 3));
        if (sel == 1) return 32'(4 * $urandom_range(MEM_WORDS, MEM_WORDS + 8));
        return 32'(4 * $urandom_range(0, MEM_WORDS - 1));
    endfunction

    // Monitor: per-cycle visible state plus scoreboard pop on every handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("imem_addr", imem_addr, m_pc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
            chk("inst_out", inst_out, m_inst);
            chk("inst_pc", inst_pc, m_ipc);
            chk("fault", {31'b0, fault}, {31'b0, m_fault});
            chk("fault_pc", fault_pc, m_fpc);
            chk("fetch_count", fetch_count, m_cnt);
            if (rst_n && inst_valid && inst_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_handshake", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", inst_pc, e.pc);
                    chk("sb_inst", inst_out, e.inst);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h1234_50b7;
        mem[1] = 32'h1234_5117;
        mem[2] = 32'h00a0_0113;
        mem[3] = 32'h0140_0093;

        do_reset();
        // Sequential, then a 3-cycle stall with PC 8 in the slot
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        // Redirect while stalled, then redirect together with a handshake
        cycle(1'b1, 1'b0, 1'b1, 32'h18);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h30);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        // Halt with a pending slot
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        // Misaligned redirect faults; nothing but reset clears it
        cycle(1'b1, 1'b0, 1'b1, 32'h1A);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h10);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Run off the end of memory: 0x7C delivered, then fault at 0x80
        do_reset();
        repeat (36) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Randomized rounds, each begun by an asynchronous reset mid-stream
        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 5) == 0, rand_target());
            end
        end

        @(negedge clk);
        #4;
        chk("sb_leftover", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
